// File: rtl/rob_retire_unit.sv
// Reorder buffer with in-order retirement and flush generation.
// Latency: dispatch/writeback visible to retire next cycle; flush pulses one cycle after the faulting retire.
// Backpressure: disp_ready drops when fewer than DISP_WIDTH entries are free or a flush is in flight; producer holds.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   disp_valid/_dst_areg/_dst_preg/_pc, disp_ready, disp_rob_idx   allocation from dispatch
//   wb_valid/_rob_idx/_exception/_br_mispred                         completion from execute pipes
//   ret_valid/_dst_areg/_dst_preg/_pc                                in-order retire lanes
//   flush, flush_pc, flush_is_exc                                    registered flush pulse
//   rob_count                                                        occupied entries
module rob_retire_unit #(
   parameter int NUM_ROB_ENTS = 64,
   parameter int DISP_WIDTH   = 2,
   parameter int RETIRE_WIDTH = 4,
   parameter int NUM_FUS      = 4,
   parameter int NUM_AREGS    = 32,
   parameter int NUM_PREGS    = 128,
   localparam int IW = $clog2(NUM_ROB_ENTS),
   localparam int AW = $clog2(NUM_AREGS),
   localparam int PW = $clog2(NUM_PREGS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DISP_WIDTH-1:0]        disp_valid,
   input  logic [DISP_WIDTH*AW-1:0]     disp_dst_areg,
   input  logic [DISP_WIDTH*PW-1:0]     disp_dst_preg,
   input  logic [DISP_WIDTH*32-1:0]     disp_pc,
   output logic                         disp_ready,
   output logic [DISP_WIDTH*IW-1:0]     disp_rob_idx,
   input  logic [NUM_FUS-1:0]           wb_valid,
   input  logic [NUM_FUS*IW-1:0]        wb_rob_idx,
   input  logic [NUM_FUS-1:0]           wb_exception,
   input  logic [NUM_FUS-1:0]           wb_br_mispred,
   output logic [RETIRE_WIDTH-1:0]      ret_valid,
   output logic [RETIRE_WIDTH*AW-1:0]   ret_dst_areg,
   output logic [RETIRE_WIDTH*PW-1:0]   ret_dst_preg,
   output logic [RETIRE_WIDTH*32-1:0]   ret_pc,
   output logic                         flush,
   output logic [31:0]                  flush_pc,
   output logic                         flush_is_exc,
   output logic [IW:0]                  rob_count
);

   localparam int CW = IW + 1;

   // Pointer and occupancy state
   logic [IW-1:0] head_q, head_d;
   logic [IW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   // Per-entry status bits, one bit per ROB slot
   logic [NUM_ROB_ENTS-1:0] valid_q, valid_d;
   logic [NUM_ROB_ENTS-1:0] done_q, done_d;
   logic [NUM_ROB_ENTS-1:0] exc_q, exc_d;
   logic [NUM_ROB_ENTS-1:0] mis_q, mis_d;

   // Payload storage; contents are only meaningful while the valid bit is set
   logic [AW-1:0] areg_q [NUM_ROB_ENTS];
   logic [PW-1:0] preg_q [NUM_ROB_ENTS];
   logic [31:0]   pc_q   [NUM_ROB_ENTS];

   // Flush output registers
   logic          flush_q;
   logic [31:0]   flush_pc_q;
   logic          flush_is_exc_q;

   // Combinational helpers
   logic                          disp_fire;
   logic [CW-1:0]                 n_disp;
   logic [NUM_ROB_ENTS-1:0]       disp_set;
   logic [NUM_ROB_ENTS-1:0]       wb_done;
   logic [NUM_ROB_ENTS-1:0]       wb_exc;
   logic [NUM_ROB_ENTS-1:0]       wb_mis;
   logic [RETIRE_WIDTH-1:0][IW-1:0] ret_idx;
   logic [NUM_ROB_ENTS-1:0]       ret_clr;
   logic [CW-1:0]                 n_ret;
   logic                          ret_stop;
   logic                          flush_trig;
   logic [31:0]                   trig_pc;
   logic                          trig_exc;

   // Ready depends on registered state only so the producer sees a stable value.
   assign disp_ready = (count_q <= CW'(NUM_ROB_ENTS - DISP_WIDTH)) && !flush_q;

   // ---------------------------------------------------------------- dispatch
   always_comb begin
      // A retiring fault wipes the ROB this cycle, so any concurrent allocation is dropped.
      disp_fire    = disp_ready && !flush_trig;
      n_disp       = '0;
      disp_set     = '0;
      disp_rob_idx = '0;
      for (int k = 0; k < DISP_WIDTH; k++) begin
         disp_rob_idx[k*IW +: IW] = tail_q + IW'(k);
         if (disp_fire && disp_valid[k]) begin
            disp_set[tail_q + IW'(k)] = 1'b1;
            n_disp = n_disp + CW'(1);
         end
      end
   end

   // --------------------------------------------------------------- writeback
   // Build set-masks first so several ports hitting one entry OR their flags together.
   always_comb begin
      wb_done = '0;
      wb_exc  = '0;
      wb_mis  = '0;
      for (int p = 0; p < NUM_FUS; p++) begin
         if (wb_valid[p] && !flush_q && valid_q[wb_rob_idx[p*IW +: IW]]) begin
            wb_done[wb_rob_idx[p*IW +: IW]] = 1'b1;
            if (wb_exception[p])  wb_exc[wb_rob_idx[p*IW +: IW]] = 1'b1;
            if (wb_br_mispred[p]) wb_mis[wb_rob_idx[p*IW +: IW]] = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------ retire
   always_comb begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         ret_idx[k] = head_q + IW'(k);
      end
   end

   always_comb begin
      ret_valid    = '0;
      ret_dst_areg = '0;
      ret_dst_preg = '0;
      ret_pc       = '0;
      ret_clr      = '0;
      n_ret        = '0;
      ret_stop     = 1'b0;
      flush_trig   = 1'b0;
      trig_pc      = '0;
      trig_exc     = 1'b0;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
         ret_dst_areg[k*AW +: AW] = areg_q[ret_idx[k]];
         ret_dst_preg[k*PW +: PW] = preg_q[ret_idx[k]];
         ret_pc[k*32 +: 32]       = pc_q[ret_idx[k]];
         // Any gap (not valid, not done, beyond count) or an earlier fault ends the retire group.
         if (!ret_stop && (CW'(k) < count_q) && valid_q[ret_idx[k]] && done_q[ret_idx[k]]) begin
            ret_valid[k]          = 1'b1;
            ret_clr[ret_idx[k]]   = 1'b1;
            n_ret                 = n_ret + CW'(1);
            if (exc_q[ret_idx[k]] || mis_q[ret_idx[k]]) begin
               ret_stop   = 1'b1;
               flush_trig = 1'b1;
               trig_pc    = pc_q[ret_idx[k]];
               trig_exc   = exc_q[ret_idx[k]];
            end
         end else begin
            ret_stop = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------- next state
   always_comb begin
      if (flush_trig) begin
         valid_d = '0;
         done_d  = '0;
         exc_d   = '0;
         mis_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         valid_d = (valid_q & ~ret_clr) | disp_set;
         // Fresh allocations start clean; stale flags from a previous occupant must not leak.
         done_d  = (done_q | wb_done) & ~disp_set;
         exc_d   = (exc_q  | wb_exc)  & ~disp_set;
         mis_d   = (mis_q  | wb_mis)  & ~disp_set;
         head_d  = head_q + n_ret[IW-1:0];
         tail_d  = tail_q + n_disp[IW-1:0];
         count_d = count_q + n_disp - n_ret;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q        <= '0;
         done_q         <= '0;
         exc_q          <= '0;
         mis_q          <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;
         flush_is_exc_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         exc_q   <= exc_d;
         mis_q   <= mis_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         flush_q <= flush_trig;
         if (flush_trig) begin
            flush_pc_q     <= trig_pc;
            flush_is_exc_q <= trig_exc;
         end
      end
   end

   // Payload needs no reset: valid gates every use.
   always_ff @(posedge clk) begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
         if (disp_fire && disp_valid[k]) begin
            areg_q[tail_q + IW'(k)] <= disp_dst_areg[k*AW +: AW];
            preg_q[tail_q + IW'(k)] <= disp_dst_preg[k*PW +: PW];
            pc_q[tail_q + IW'(k)]   <= disp_pc[k*32 +: 32];
         end
      end
   end

   assign flush        = flush_q;
   assign flush_pc     = flush_pc_q;
   assign flush_is_exc = flush_is_exc_q;
   assign rob_count    = count_q;

`ifndef SYNTHESIS
   // Dispatch lanes must be filled from lane 0 upward with no holes.
   disp_contig_a: assert property (@(posedge clk) disable iff (!rst_n)
      (disp_valid & (disp_valid + DISP_WIDTH'(1))) == '0);
`endif

endmodule

// File: tb/tb_rob_retire_unit.sv
module tb_rob_retire_unit;

   localparam int IW = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   disp_valid = '0;
   logic [9:0]   disp_dst_areg = '0;
   logic [13:0]  disp_dst_preg = '0;
   logic [63:0]  disp_pc = '0;
   logic         disp_ready;
   logic [11:0]  disp_rob_idx;
   logic [3:0]   wb_valid = '0;
   logic [23:0]  wb_rob_idx = '0;
   logic [3:0]   wb_exception = '0;
   logic [3:0]   wb_br_mispred = '0;
   logic [3:0]   ret_valid;
   logic [19:0]  ret_dst_areg;
   logic [27:0]  ret_dst_preg;
   logic [127:0] ret_pc;
   logic         flush;
   logic [31:0]  flush_pc;
   logic         flush_is_exc;
   logic [6:0]   rob_count;

   rob_retire_unit dut (
      .clk(clk), .rst_n(rst_n),
      .disp_valid(disp_valid), .disp_dst_areg(disp_dst_areg), .disp_dst_preg(disp_dst_preg),
      .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
      .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_exception(wb_exception),
      .wb_br_mispred(wb_br_mispred),
      .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg), .ret_dst_preg(ret_dst_preg),
      .ret_pc(ret_pc), .flush(flush), .flush_pc(flush_pc), .flush_is_exc(flush_is_exc),
      .rob_count(rob_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [4:0]  areg;
      logic [6:0]  preg;
      logic [31:0] pc;
   } ent_t;

   ent_t exp_q[$];
   logic [31:0] next_pc = 32'h100;

   typedef struct packed {
      logic [1:0]  nd;
      logic [3:0]  wbv;
      logic [23:0] wbi;
      logic [3:0]  wbe;
      logic [3:0]  wbm;
      logic        chk_idx;
      logic [11:0] exp_idx;
      logic [3:0]  exp_ret;
      logic [6:0]  exp_cnt;
      logic        exp_rdy;
      logic        exp_fl;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
      return {6'(d), 6'(c), 6'(b), 6'(a)};
   endfunction

   function automatic vec_t mk(input int nd, input logic [3:0] wbv, input logic [23:0] wbi,
                               input logic [3:0] wbe, input logic [3:0] wbm, input logic ci,
                               input logic [11:0] ei, input logic [3:0] er, input int ec,
                               input logic rdy, input logic fl);
      vec_t v;
      v.nd = 2'(nd); v.wbv = wbv; v.wbi = wbi; v.wbe = wbe; v.wbm = wbm;
      v.chk_idx = ci; v.exp_idx = ei; v.exp_ret = er; v.exp_cnt = 7'(ec);
      v.exp_rdy = rdy; v.exp_fl = fl;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus; accepted dispatch lanes go onto the scoreboard in program order.
   task automatic drive(input int nd, input logic [3:0] wbv, input logic [23:0] wbi,
                        input logic [3:0] wbe, input logic [3:0] wbm);
      logic [31:0] pc;
      ent_t e;
      disp_valid = 2'((1 << nd) - 1);
      for (int k = 0; k < 2; k++) begin
         pc = next_pc + 32'(4 * k);
         disp_pc[k*32 +: 32]      = pc;
         disp_dst_areg[k*5 +: 5]  = pc[6:2];
         disp_dst_preg[k*7 +: 7]  = pc[8:2];
         if (disp_ready && k < nd) begin
            e.areg = pc[6:2]; e.preg = pc[8:2]; e.pc = pc;
            exp_q.push_back(e);
         end
      end
      if (disp_ready) next_pc = next_pc + 32'(4 * nd);
      wb_valid = wbv; wb_rob_idx = wbi; wb_exception = wbe; wb_br_mispred = wbm;
   endtask

   task automatic cyc(input int nd, input logic [3:0] wbv, input logic [23:0] wbi,
                      input logic [3:0] wbe, input logic [3:0] wbm);
      drive(nd, wbv, wbi, wbe, wbm);
      tick();
   endtask

   task automatic idle();
      cyc(0, 4'b0, 24'h0, 4'b0, 4'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 4'b0, 24'h0, 4'b0, 4'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(rob_count), 64'd0);
      chk("rst_ready", 64'(disp_ready), 64'd1);
      chk("rst_ret", 64'(ret_valid), 64'd0);
      chk("rst_flush", 64'({flush, flush_is_exc, flush_pc}), 64'd0);
      rst_n = 1'b1;
      exp_q.delete();
      tick();
   endtask

   // Scoreboard: every retiring lane must match the oldest outstanding dispatch.
   always @(negedge clk) begin
      if (rst_n) begin
         if (flush) exp_q.delete();
         for (int k = 0; k < 4; k++) begin
            if (ret_valid[k]) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_lane%0d: retired pc 0x%0h, want nothing outstanding", k, ret_pc[k*32 +: 32]);
               end else begin
                  ent_t e;
                  e = exp_q.pop_front();
                  chk("sb_pc",   64'(ret_pc[k*32 +: 32]),      64'(e.pc));
                  chk("sb_areg", 64'(ret_dst_areg[k*5 +: 5]),  64'(e.areg));
                  chk("sb_preg", 64'(ret_dst_preg[k*7 +: 7]),  64'(e.preg));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int budget;

      // ---------------- reset, single retire, dispatch/retire overlap (table)
      vecs[0] = mk(2, 4'b0000, pk(0,0,0,0), 4'b0, 4'b0, 1'b1, {6'd1, 6'd0}, 4'b0000, 2, 1'b1, 1'b0);
      vecs[1] = mk(0, 4'b0001, pk(1,0,0,0), 4'b0, 4'b0, 1'b0, 12'h0,        4'b0000, 2, 1'b1, 1'b0);
      vecs[2] = mk(0, 4'b0001, pk(0,0,0,0), 4'b0, 4'b0, 1'b0, 12'h0,        4'b0011, 2, 1'b1, 1'b0);
      vecs[3] = mk(0, 4'b0000, pk(0,0,0,0), 4'b0, 4'b0, 1'b0, 12'h0,        4'b0000, 0, 1'b1, 1'b0);
      vecs[4] = mk(1, 4'b0000, pk(0,0,0,0), 4'b0, 4'b0, 1'b1, {6'd3, 6'd2}, 4'b0000, 1, 1'b1, 1'b0);
      vecs[5] = mk(0, 4'b0001, pk(2,0,0,0), 4'b0, 4'b0, 1'b0, 12'h0,        4'b0001, 1, 1'b1, 1'b0);
      vecs[6] = mk(2, 4'b0000, pk(0,0,0,0), 4'b0, 4'b0, 1'b1, {6'd4, 6'd3}, 4'b0000, 2, 1'b1, 1'b0);

      do_reset();
      next_pc = 32'h100;
      foreach (vecs[i]) begin
         if (vecs[i].chk_idx) chk($sformatf("v%0d_idx", i), 64'(disp_rob_idx), 64'(vecs[i].exp_idx));
         cyc(int'(vecs[i].nd), vecs[i].wbv, vecs[i].wbi, vecs[i].wbe, vecs[i].wbm);
         chk($sformatf("v%0d_ret", i),   64'(ret_valid),  64'(vecs[i].exp_ret));
         chk($sformatf("v%0d_cnt", i),   64'(rob_count),  64'(vecs[i].exp_cnt));
         chk($sformatf("v%0d_rdy", i),   64'(disp_ready), 64'(vecs[i].exp_rdy));
         chk($sformatf("v%0d_flush", i), 64'(flush),      64'(vecs[i].exp_fl));
      end

      // ---------------- fill to full
      do_reset();
      next_pc = 32'h1000;
      repeat (32) cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("full_cnt", 64'(rob_count), 64'd64);
      chk("full_rdy", 64'(disp_ready), 64'd0);
      cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("full_hold_cnt", 64'(rob_count), 64'd64);
      cyc(0, 4'b1111, pk(0,1,2,3), 4'b0, 4'b0);
      chk("full_ret", 64'(ret_valid), 64'hF);
      idle();
      chk("full_drain_cnt", 64'(rob_count), 64'd60);
      chk("full_drain_rdy", 64'(disp_ready), 64'd1);

      // ---------------- count=63 boundary
      do_reset();
      repeat (31) cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("c62_rdy", 64'(disp_ready), 64'd1);
      cyc(1, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("c63_cnt", 64'(rob_count), 64'd63);
      chk("c63_rdy", 64'(disp_ready), 64'd0);
      cyc(0, 4'b0001, pk(0,0,0,0), 4'b0, 4'b0);
      chk("c63_ret", 64'(ret_valid), 64'h1);
      idle();
      chk("c62b_rdy", 64'(disp_ready), 64'd1);

      // ---------------- mispredict flush
      do_reset();
      next_pc = 32'h200;
      repeat (3) cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      cyc(0, 4'b1111, pk(0,1,2,3), 4'b0000, 4'b0010);
      chk("mis_ret", 64'(ret_valid), 64'h3);
      chk("mis_preflush", 64'(flush), 64'd0);
      cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);   // dispatch in the faulting cycle is dropped
      chk("mis_flush", 64'(flush), 64'd1);
      chk("mis_pc", 64'(flush_pc), 64'h204);
      chk("mis_isexc", 64'(flush_is_exc), 64'd0);
      chk("mis_cnt", 64'(rob_count), 64'd0);
      chk("mis_rdy", 64'(disp_ready), 64'd0);
      chk("mis_retoff", 64'(ret_valid), 64'd0);
      chk("mis_idx", 64'(disp_rob_idx), 64'({6'd1, 6'd0}));
      cyc(2, 4'b0001, pk(0,0,0,0), 4'b0, 4'b0);
      chk("mis_after_flush", 64'(flush), 64'd0);
      chk("mis_after_rdy", 64'(disp_ready), 64'd1);
      chk("mis_after_cnt", 64'(rob_count), 64'd0);
      cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("mis_redisp_cnt", 64'(rob_count), 64'd2);

      // ---------------- stale and duplicate writeback
      do_reset();
      next_pc = 32'h300;
      cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      cyc(0, 4'b0001, pk(9,0,0,0), 4'b0001, 4'b0);
      chk("stale_ret", 64'(ret_valid), 64'd0);
      chk("stale_cnt", 64'(rob_count), 64'd2);
      idle();
      chk("stale_flush", 64'(flush), 64'd0);
      cyc(0, 4'b0111, pk(0,0,1,0), 4'b0010, 4'b0001);
      chk("dup_ret", 64'(ret_valid), 64'h1);
      idle();
      chk("dup_flush", 64'(flush), 64'd1);
      chk("dup_isexc", 64'(flush_is_exc), 64'd1);
      chk("dup_pc", 64'(flush_pc), 64'h300);
      chk("dup_cnt", 64'(rob_count), 64'd0);

      // ---------------- wrap around the end of the buffer
      do_reset();
      next_pc = 32'h400;
      for (int i = 0; i < 31; i++) begin
         if (i > 0) cyc(2, 4'b0011, pk(2*i-2, 2*i-1, 0, 0), 4'b0, 4'b0);
         else       cyc(2, 4'b0000, 24'h0, 4'b0, 4'b0);
      end
      cyc(0, 4'b0011, pk(60, 61, 0, 0), 4'b0, 4'b0);
      budget = 20;
      while (rob_count != 0 && budget > 0) begin
         idle();
         budget--;
      end
      chk("wrap_drain_cnt", 64'(rob_count), 64'd0);
      chk("wrap_idx62", 64'(disp_rob_idx), 64'({6'd63, 6'd62}));
      cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("wrap_idx0", 64'(disp_rob_idx), 64'({6'd1, 6'd0}));
      cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      cyc(0, 4'b1111, pk(62, 63, 0, 1), 4'b0, 4'b0);
      chk("wrap_ret", 64'(ret_valid), 64'hF);
      chk("wrap_cnt4", 64'(rob_count), 64'd4);
      idle();
      chk("wrap_cnt0", 64'(rob_count), 64'd0);
      chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

      // ---------------- async reset mid-stream
      do_reset();
      repeat (5) cyc(2, 4'b0, 24'h0, 4'b0, 4'b0);
      chk("ar_cnt10", 64'(rob_count), 64'd10);
      cyc(0, 4'b0011, pk(0, 1, 0, 0), 4'b0, 4'b0);
      chk("ar_ret_before", 64'(ret_valid), 64'h3);
      rst_n = 1'b0;
      #1;
      chk("ar_cnt", 64'(rob_count), 64'd0);
      chk("ar_ret", 64'(ret_valid), 64'd0);
      chk("ar_flush", 64'(flush), 64'd0);
      chk("ar_rdy", 64'(disp_ready), 64'd1);
      drive(0, 4'b0, 24'h0, 4'b0, 4'b0);
      #4;
      rst_n = 1'b1;
      exp_q.delete();
      tick();
      chk("ar_post_cnt", 64'(rob_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
- In-order reorder buffer and retirement reader for the out-of-order core.
- Dispatch writes up to DISP_WIDTH ROB entries per cycle (dst areg, dst preg, pc). Execute pipes mark entries complete with exception and branch-mispredict flags.
- This block reads entries from the head and retires up to RETIRE_WIDTH per cycle, strictly in program order.
- A retired exception or mispredict raises a pipeline flush.

Parameters:
- NUM_ROB_ENTS, 64, entries in circular buffer (power of 2)
- DISP_WIDTH, 2, dispatch lanes per cycle
- RETIRE_WIDTH, 4, retire lanes per cycle
- NUM_FUS, 4, writeback ports
- NUM_AREGS, 32, architectural registers
- NUM_PREGS, 128, physical registers
- Derived widths: IW=$clog2(NUM_ROB_ENTS), AW=$clog2(NUM_AREGS), PW=$clog2(NUM_PREGS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  DISP_WIDTH  per-lane allocate request; lanes contiguous from lane 0
- disp_dst_areg  in  DISP_WIDTH*AW  destination architectural register per lane
- disp_dst_preg  in  DISP_WIDTH*PW  destination physical register per lane
- disp_pc  in  DISP_WIDTH*32  instruction pc per lane
- disp_ready  out  1  at least DISP_WIDTH free entries, and no flush pending
- disp_rob_idx  out  DISP_WIDTH*IW  index allocated to each lane (tail+k)
- wb_valid  in  NUM_FUS  completion strobe per port
- wb_rob_idx  in  NUM_FUS*IW  completing entry index
- wb_exception  in  NUM_FUS  entry raised exception
- wb_br_mispred  in  NUM_FUS  entry was a mispredicted branch
- ret_valid  out  RETIRE_WIDTH  lane k retires entry head+k this cycle
- ret_dst_areg  out  RETIRE_WIDTH*AW  retiring areg
- ret_dst_preg  out  RETIRE_WIDTH*PW  retiring preg, for freelist and RAT commit
- ret_pc  out  RETIRE_WIDTH*32  retiring pc
- flush  out  1  one-cycle registered flush pulse
- flush_pc  out  32  pc of the faulting entry
- flush_is_exc  out  1  1 = exception, 0 = mispredict
- rob_count  out  IW+1  occupied entries

Behaviour:
- **Reset (async, rst_n=0):**
  - head=tail=0, count=0; all valid/done bits cleared.
  - flush=0, flush_pc=0, flush_is_exc=0.
  - ret_valid=0, disp_ready=1.
  - Reset mid-operation discards all entries immediately.
- **Pointers:**
  - head and tail are IW bits and wrap modulo NUM_ROB_ENTS.
  - count (IW+1 bits) disambiguates full from empty.
  - Next count = count + n_disp - n_ret. Simultaneous dispatch and retire in one cycle is legal.
- **Dispatch:**
  - disp_ready = (NUM_ROB_ENTS - count >= DISP_WIDTH) && !flush. It is computed from registered state only.
  - When disp_ready=1, each valid lane k writes entry tail+k with valid=1, done=0, exc=0, mis=0.
  - tail advances by popcount(disp_valid).
  - disp_valid with disp_ready=0 is ignored; the producer holds.
  - Non-contiguous disp_valid is illegal; the assertion fires in sim.
- **Writeback:**
  - For each wb_valid port, set done and OR in the exc/mis flags of entry wb_rob_idx.
  - A writeback to an entry with valid=0 is ignored.
  - Two ports targeting the same index in one cycle: flags are ORed.
  - Done is visible to retire the next cycle; minimum writeback-to-retire latency is 1 cycle.
- **Retire (combinational from registered state):**
  - Lane k is eligible when k < count and entries head..head+k are all valid and done.
  - No lower lane may carry exc or mis.
  - The first exc/mis entry retires, with ret_valid asserted, and stops further lanes that cycle.
  - head advances by n_ret; retired entries have valid cleared.
- **Flush:**
  - A flush is triggered when a retiring lane carries exc or mis in cycle N.
  - At the end of cycle N, all entries are invalidated and head=tail=count=0. Any dispatch in cycle N is dropped.
  - In cycle N+1: flush=1, flush_pc = that entry's pc, flush_is_exc=exc. In the same cycle, disp_ready=0, ret_valid=0, and writebacks are ignored.
  - exc takes priority over mis for flush_is_exc.
- **Boundary cases:**
  - Full (count=64): disp_ready=0.
  - count=63 with DISP_WIDTH=2: disp_ready=0.
  - Wrap from head=62 retires entries 62,63,0,1 in lanes 0..3.

Test Plan:
- **Reset, single retire:** reset, dispatch lanes 0,1 (pc 0x100, 0x104) -> disp_rob_idx=0,1, rob_count=2. Then writeback idx 1 only -> ret_valid=0. Then writeback idx 0 -> next cycle ret_valid=4'b0011, head=2.
- **Fill to full:** dispatch 32 cycles of 2 -> rob_count=64, disp_ready=0. Complete idx 0..3 -> ret_valid=4'b1111, rob_count=60, disp_ready=1.
- **Mispredict flush:** entries 0..3 done, idx 1 mispredicted (pc 0x204) -> ret_valid=4'b0011. Next cycle flush=1, flush_pc=0x204, flush_is_exc=0, rob_count=0, disp_ready=0. The following cycle disp_ready=1.
- **Wrap:** advance head to 62, complete entries 62,63,0,1 -> retire all four in one cycle, head=2.
- **Stale and duplicate writeback:** writeback to an unallocated idx -> no state change. Two ports hit the same idx with exc on one -> flush with flush_is_exc=1.
- **Async reset mid-stream:** rst_n low with 10 entries -> rob_count=0, ret_valid=0, flush=0 without a clock edge.
